// File: rtl/booth_r8_mac_pipe.sv
// booth_r8_mac_pipe: 5-stage radix-8 Booth multiplier with a wide
// signed/unsigned accumulator, sticky overflow and valid/ready flow control.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input beat handshake (in_ready = ~stall)
//   a, b [W]            multiplicand / multiplier
//   sm [2]              [1] a signed, [0] b signed
//   acc_en, acc_clr     beat accumulates / beat reloads the accumulator
//   out_valid/out_ready output handshake
//   p [2W]              product of the beat
//   acc [ACC_W]         accumulator after the beat
//   acc_ovf             sticky accumulation overflow
module booth_r8_mac_pipe #(
    parameter int W     = 8,
    parameter int ACC_W = 2*W+8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       sm,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    localparam int NPP = (W+3)/3;
    localparam int XW  = W+3;
    localparam int BW  = 3*NPP+1;
    localparam int EW  = BW-1-W;
    localparam int PW  = 2*W;

    logic w_stall;

    logic r1_v, r2_v, r3_v, r4_v, r5_v;

    logic [XW-1:0] r1_a;
    logic [BW-1:0] r1_b;
    logic [1:0]    r1_sm;
    logic          r1_en, r1_clr;

    logic [XW-1:0] r2_m1, r2_m2, r2_m3, r2_m4;
    logic [BW-1:0] r2_b;
    logic [1:0]    r2_sm;
    logic          r2_en, r2_clr;

    // terms[0..NPP-1] are partial products, terms[NPP] the +1 corrections
    logic [PW-1:0] r3_t [NPP+1];
    logic [1:0]    r3_sm;
    logic          r3_en, r3_clr;

    logic [PW-1:0] r4_s, r4_c;
    logic [1:0]    r4_sm;
    logic          r4_en, r4_clr;

    logic [PW-1:0]    r_p;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic [XW-1:0]    w_aext;
    logic [BW-1:0]    w_bfmt;
    logic [XW-1:0]    w_m2, w_m3, w_m4;
    logic [PW-1:0]    w_t [NPP+1];
    logic [PW-1:0]    w_s, w_c;
    logic [PW-1:0]    w_p;
    logic [ACC_W-1:0] w_pse, w_pze, w_pext, w_base;
    logic [ACC_W:0]   w_sum;
    logic             w_sgn, w_ovf_s, w_ovf;

    assign w_stall   = r5_v & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r5_v;
    assign p         = r_p;
    assign acc       = r_acc;
    assign acc_ovf   = r_ovf;

    // Valid chain: bubbles travel with the data, whole pipe freezes on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_v <= 1'b0;
            r2_v <= 1'b0;
            r3_v <= 1'b0;
            r4_v <= 1'b0;
            r5_v <= 1'b0;
        end else if (!w_stall) begin
            r1_v <= in_valid;
            r2_v <= r1_v;
            r3_v <= r2_v;
            r4_v <= r3_v;
            r5_v <= r4_v;
        end
    end

    // S1: operand formatting
    assign w_aext = sm[1] ? XW'($signed(a)) : XW'(a);
    // Extension bits above b keep the top window's sign right; trailing 0
    // is the implicit y[-1] of the Booth recoding.
    assign w_bfmt = {{EW{sm[0] & b[W-1]}}, b, 1'b0};

    // S2: multiples
    assign w_m2 = r1_a << 1;
    assign w_m4 = r1_a << 2;
    assign w_m3 = r1_a + w_m2;

    // S3: window decode; negative digits use ~M here and +1 in the
    // correction term, so no adder per partial product.
    always_comb begin
        logic [3:0]    v_win;
        logic [3:0]    v_sel;
        logic [XW-1:0] v_mul;
        v_win = '0;
        v_sel = '0;
        v_mul = '0;
        for (int k = 0; k <= NPP; k++) w_t[k] = '0;
        for (int k = 0; k < NPP; k++) begin
            v_win = r2_b[3*k +: 4];
            case (v_win)
                4'b0001, 4'b0010,
                4'b1101, 4'b1110: v_sel = 4'b0001;
                4'b0011, 4'b0100,
                4'b1011, 4'b1100: v_sel = 4'b0010;
                4'b0101, 4'b0110,
                4'b1001, 4'b1010: v_sel = 4'b0100;
                4'b0111, 4'b1000: v_sel = 4'b1000;
                default:          v_sel = 4'b0000;
            endcase
            v_mul = ({XW{v_sel[0]}} & r2_m1)
                  | ({XW{v_sel[1]}} & r2_m2)
                  | ({XW{v_sel[2]}} & r2_m3)
                  | ({XW{v_sel[3]}} & r2_m4);
            v_mul = v_mul ^ {XW{v_win[3]}};
            w_t[k] = PW'($signed(v_mul)) << (3*k);
            w_t[NPP][3*k] = v_win[3];
        end
    end

    // S4: carry-save reduction of all terms to two vectors
    always_comb begin
        logic [PW-1:0] v_t;
        logic [PW-1:0] v_s;
        logic [PW-1:0] v_c;
        v_s = w_t[0];
        v_c = w_t[1];
        v_t = '0;
        v_s = r3_t[0];
        v_c = r3_t[1];
        for (int k = 2; k <= NPP; k++) begin
            v_t = r3_t[k];
            {v_s, v_c} = {v_s ^ v_c ^ v_t,
                          ((v_s & v_c) | (v_s & v_t) | (v_c & v_t)) << 1};
        end
        w_s = v_s;
        w_c = v_c;
    end

    // S5: final add and accumulate
    assign w_p    = r4_s + r4_c;
    assign w_sgn  = |r4_sm;
    assign w_pse  = ACC_W'($signed(w_p));
    assign w_pze  = ACC_W'(w_p);
    assign w_pext = w_sgn ? w_pse : w_pze;
    assign w_base = r4_clr ? '0 : r_acc;
    assign w_sum  = {1'b0, w_base} + {1'b0, w_pext};
    assign w_ovf_s = (w_base[ACC_W-1] == w_pext[ACC_W-1])
                   & (w_sum[ACC_W-1] != w_base[ACC_W-1]);
    assign w_ovf  = w_sgn ? w_ovf_s : w_sum[ACC_W];

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_a   <= w_aext;
            r1_b   <= w_bfmt;
            r1_sm  <= sm;
            r1_en  <= acc_en;
            r1_clr <= acc_clr;

            r2_m1  <= r1_a;
            r2_m2  <= w_m2;
            r2_m3  <= w_m3;
            r2_m4  <= w_m4;
            r2_b   <= r1_b;
            r2_sm  <= r1_sm;
            r2_en  <= r1_en;
            r2_clr <= r1_clr;

            for (int k = 0; k <= NPP; k++) r3_t[k] <= w_t[k];
            r3_sm  <= r2_sm;
            r3_en  <= r2_en;
            r3_clr <= r2_clr;

            r4_s   <= w_s;
            r4_c   <= w_c;
            r4_sm  <= r3_sm;
            r4_en  <= r3_en;
            r4_clr <= r3_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (!w_stall && r4_v) begin
            r_p <= w_p;
            if (r4_en) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= (r_ovf & ~r4_clr) | w_ovf;
            end
        end
    end

endmodule
